// File: rtl/vga_window_scaler.sv
// Programmable-timing VGA generator with integer upscaling of a small frame buffer into a fixed window.
// Addresses come from step counters rather than a multiplier; sync/DE are delayed to meet RAM read data.
module vga_window_scaler #(
    parameter int   H_ACTIVE = 1280,
    parameter int   H_FP     = 110,
    parameter int   H_SYNC   = 40,
    parameter int   H_BP     = 220,
    parameter int   V_ACTIVE = 720,
    parameter int   V_FP     = 5,
    parameter int   V_SYNC   = 5,
    parameter int   V_BP     = 20,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1,
    parameter int   SRC_W    = 160,
    parameter int   SRC_H    = 144,
    parameter int   SCALE    = 4,
    parameter int   WIN_X    = 320,
    parameter int   WIN_Y    = 72,
    parameter int   ADDR_W   = 15,
    parameter int   COLOR_W  = 8,
    parameter int   RAM_LAT  = 1
) (
    input  logic               CLK_IN,
    input  logic               RESET_N,
    input  logic [COLOR_W-1:0] BORDER_COLOR,
    output logic [ADDR_W-1:0]  VRAM_ADDR,
    output logic               VRAM_RD,
    input  logic [COLOR_W-1:0] VRAM_DATA,
    output logic               HSync,
    output logic               VSync,
    output logic               DE,
    output logic [COLOR_W-1:0] COLOR_OUT,
    output logic               FRAME_START
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);
    localparam int unsigned WIN_W   = SRC_W * SCALE;
    localparam int unsigned WIN_H   = SRC_H * SCALE;
    localparam int unsigned HA      = H_ACTIVE;
    localparam int unsigned VA      = V_ACTIVE;
    localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
    localparam int unsigned HS_END  = H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
    localparam int unsigned VS_END  = V_ACTIVE + V_FP + V_SYNC;
    localparam int unsigned WX0     = WIN_X;
    localparam int unsigned WX1     = WIN_X + WIN_W;
    localparam int unsigned WY0     = WIN_Y;
    localparam int unsigned WY1     = WIN_Y + WIN_H;
    localparam int unsigned SW      = (SCALE > 1) ? $clog2(SCALE) : 1;

    localparam logic [SW-1:0]     SUB_LAST = SW'(SCALE - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(SRC_W);

    if (SCALE < 1) begin : g_bad_scale
        $fatal(1, "vga_window_scaler: SCALE must be >= 1");
    end
    if (RAM_LAT < 1) begin : g_bad_lat
        $fatal(1, "vga_window_scaler: RAM_LAT must be >= 1");
    end
    if ((WIN_X + SRC_W * SCALE > H_ACTIVE) || (WIN_Y + SRC_H * SCALE > V_ACTIVE)) begin : g_bad_win
        $fatal(1, "vga_window_scaler: window exceeds active area");
    end
    if (longint'(SRC_W) * longint'(SRC_H) > (longint'(1) << ADDR_W)) begin : g_bad_addr
        $fatal(1, "vga_window_scaler: source frame does not fit ADDR_W");
    end

    typedef struct packed {
        logic fs;
        logic win;
        logic de;
        logic vs;
        logic hs;
    } ctrl_t;

    logic [HW-1:0]     h;
    logic [VW-1:0]     v;
    logic [31:0]       hu;
    logic [31:0]       vu;
    logic              h_last;
    logic              v_last;
    logic              win_x;
    logic              win_y;
    logic              line_end;
    ctrl_t             ctrl_now;
    ctrl_t             ctrl_s1;
    ctrl_t             ctrl_pipe [RAM_LAT];
    ctrl_t             ctrl_last;
    logic [SW-1:0]     sub_x;
    logic [SW-1:0]     sub_y;
    logic [ADDR_W-1:0] src_x;
    logic [ADDR_W-1:0] row_base;

    always_comb begin
        hu           = 32'(h);
        vu           = 32'(v);
        h_last       = (hu == H_TOTAL - 1);
        v_last       = (vu == V_TOTAL - 1);
        win_x        = (hu >= WX0) && (hu < WX1);
        win_y        = (vu >= WY0) && (vu < WY1);
        line_end     = win_x && win_y && (hu == WX1 - 1);
        ctrl_now     = '0;
        ctrl_now.fs  = (hu == 0) && (vu == 0);
        ctrl_now.win = win_x && win_y;
        ctrl_now.de  = (hu < HA) && (vu < VA);
        ctrl_now.hs  = (hu >= HS_BEG) && (hu < HS_END);
        ctrl_now.vs  = (vu >= VS_BEG) && (vu < VS_END);
    end

    always_ff @(posedge CLK_IN) begin
        if (!RESET_N) begin
            h <= '0;
            v <= '0;
        end else if (h_last) begin
            h <= '0;
            v <= v_last ? '0 : v + 1'b1;
        end else begin
            h <= h + 1'b1;
        end
    end

    // Address stage: src_x advances every SCALE window pixels, row_base every SCALE window lines.
    always_ff @(posedge CLK_IN) begin
        if (!RESET_N) begin
            sub_x     <= '0;
            sub_y     <= '0;
            src_x     <= '0;
            row_base  <= '0;
            VRAM_ADDR <= '0;
            VRAM_RD   <= 1'b0;
            ctrl_s1   <= '0;
        end else begin
            ctrl_s1 <= ctrl_now;
            VRAM_RD <= ctrl_now.win;
            if (ctrl_now.win) begin
                VRAM_ADDR <= row_base + src_x;
                if (sub_x == SUB_LAST) begin
                    sub_x <= '0;
                    src_x <= src_x + 1'b1;
                end else begin
                    sub_x <= sub_x + 1'b1;
                end
            end else begin
                sub_x <= '0;
                src_x <= '0;
            end
            if (!win_y) begin
                sub_y    <= '0;
                row_base <= '0;
            end else if (line_end) begin
                if (sub_y == SUB_LAST) begin
                    sub_y    <= '0;
                    row_base <= row_base + ROW_STEP;
                end else begin
                    sub_y <= sub_y + 1'b1;
                end
            end
        end
    end

    // Control waits RAM_LAT cycles so it lines up with VRAM_DATA at the output register.
    always_ff @(posedge CLK_IN) begin
        if (!RESET_N) begin
            for (int unsigned i = 0; i < RAM_LAT; i++) begin
                ctrl_pipe[i] <= '0;
            end
        end else begin
            ctrl_pipe[0] <= ctrl_s1;
            for (int unsigned i = 1; i < RAM_LAT; i++) begin
                ctrl_pipe[i] <= ctrl_pipe[i-1];
            end
        end
    end

    assign ctrl_last = ctrl_pipe[RAM_LAT-1];

    always_ff @(posedge CLK_IN) begin
        if (!RESET_N) begin
            HSync       <= ~HS_POL;
            VSync       <= ~VS_POL;
            DE          <= 1'b0;
            COLOR_OUT   <= '0;
            FRAME_START <= 1'b0;
        end else begin
            HSync       <= ctrl_last.hs ? HS_POL : ~HS_POL;
            VSync       <= ctrl_last.vs ? VS_POL : ~VS_POL;
            DE          <= ctrl_last.de;
            FRAME_START <= ctrl_last.fs;
            if (ctrl_last.win) begin
                COLOR_OUT <= VRAM_DATA;
            end else if (ctrl_last.de) begin
                COLOR_OUT <= BORDER_COLOR;
            end else begin
                COLOR_OUT <= '0;
            end
        end
    end

endmodule

// File: tb/tb_vga_window_scaler.sv
// Bench for vga_window_scaler: three small-timing instances (default, inverted sync, RAM_LAT=2)
// compared every cycle against a frame-position reference model.
module tb_vga_window_scaler;

    localparam int HT = 24;
    localparam int VT = 16;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  border;

    logic [14:0] a_addr, b_addr, c_addr;
    logic        a_rd, b_rd, c_rd;
    logic [7:0]  a_data, b_data, c_data, c_d1;
    logic        a_hs, a_vs, a_de, a_fs;
    logic        b_hs, b_vs, b_de, b_fs;
    logic        c_hs, c_vs, c_de, c_fs;
    logic [7:0]  a_color, b_color, c_color;

    int          vectors = 0;
    int          miscompares = 0;
    int          k = 0;
    logic [14:0] last_addr = '0;
    logic        exp_rd = 1'b0;

    always #5 clk = ~clk;

    vga_window_scaler #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1),
        .SRC_W(4), .SRC_H(3), .SCALE(2), .WIN_X(4), .WIN_Y(3),
        .ADDR_W(15), .COLOR_W(8), .RAM_LAT(1)
    ) dut (
        .CLK_IN(clk), .RESET_N(reset_n), .BORDER_COLOR(border),
        .VRAM_ADDR(a_addr), .VRAM_RD(a_rd), .VRAM_DATA(a_data),
        .HSync(a_hs), .VSync(a_vs), .DE(a_de), .COLOR_OUT(a_color), .FRAME_START(a_fs)
    );

    vga_window_scaler #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0),
        .SRC_W(4), .SRC_H(3), .SCALE(2), .WIN_X(4), .WIN_Y(3),
        .ADDR_W(15), .COLOR_W(8), .RAM_LAT(1)
    ) dut_neg (
        .CLK_IN(clk), .RESET_N(reset_n), .BORDER_COLOR(border),
        .VRAM_ADDR(b_addr), .VRAM_RD(b_rd), .VRAM_DATA(b_data),
        .HSync(b_hs), .VSync(b_vs), .DE(b_de), .COLOR_OUT(b_color), .FRAME_START(b_fs)
    );

    vga_window_scaler #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1),
        .SRC_W(4), .SRC_H(3), .SCALE(2), .WIN_X(4), .WIN_Y(3),
        .ADDR_W(15), .COLOR_W(8), .RAM_LAT(2)
    ) dut_lat2 (
        .CLK_IN(clk), .RESET_N(reset_n), .BORDER_COLOR(border),
        .VRAM_ADDR(c_addr), .VRAM_RD(c_rd), .VRAM_DATA(c_data),
        .HSync(c_hs), .VSync(c_vs), .DE(c_de), .COLOR_OUT(c_color), .FRAME_START(c_fs)
    );

    // Synchronous RAM models whose contents equal their address.
    always @(posedge clk) begin
        a_data <= a_addr[7:0];
        b_data <= b_addr[7:0];
        c_d1   <= c_addr[7:0];
        c_data <= c_d1;
    end

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic       fs;
        logic [7:0] color;
    } vid_t;

    function automatic void pix_geom(input int p, output int h, output int v,
                                     output logic win, output logic [14:0] addr);
        h    = p % HT;
        v    = (p / HT) % VT;
        win  = (h >= 4) && (h < 12) && (v >= 3) && (v < 9);
        addr = win ? 15'(((v - 3) / 2) * 4 + (h - 4) / 2) : 15'd0;
    endfunction

    function automatic vid_t expect_vid(input int kk, input int lat, input logic hpol,
                                        input logic vpol, input logic [7:0] bc);
        vid_t        r;
        int          h, v;
        logic        win;
        logic [14:0] a;
        r.hs    = ~hpol;
        r.vs    = ~vpol;
        r.de    = 1'b0;
        r.fs    = 1'b0;
        r.color = 8'h00;
        if (kk >= lat) begin
            pix_geom(kk - lat, h, v, win, a);
            r.de    = (h < 16) && (v < 12);
            r.hs    = (h >= 18 && h < 21) ? hpol : ~hpol;
            r.vs    = (v >= 13 && v < 15) ? vpol : ~vpol;
            r.fs    = (h == 0) && (v == 0);
            r.color = win ? a[7:0] : (r.de ? bc : 8'h00);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h (k=%0d)", tag, obs, exp, k);
        end
    endtask

    task automatic step(input logic rst, input logic [7:0] bc);
        int          h, v;
        logic        win;
        logic [14:0] a;
        vid_t        e;
        reset_n = rst;
        border  = bc;
        @(posedge clk);
        if (!rst) begin
            k         = 0;
            last_addr = '0;
            exp_rd    = 1'b0;
        end else begin
            k++;
            pix_geom(k - 1, h, v, win, a);
            exp_rd = win;
            if (win) last_addr = a;
        end
        @(negedge clk);
        chk("a_vram_rd", 32'(a_rd), 32'(exp_rd));
        chk("a_vram_addr", 32'(a_addr), 32'(last_addr));
        chk("c_vram_rd", 32'(c_rd), 32'(exp_rd));
        chk("c_vram_addr", 32'(c_addr), 32'(last_addr));
        e = expect_vid(k, 3, 1'b1, 1'b1, bc);
        chk("a_hsync", 32'(a_hs), 32'(e.hs));
        chk("a_vsync", 32'(a_vs), 32'(e.vs));
        chk("a_de", 32'(a_de), 32'(e.de));
        chk("a_frame_start", 32'(a_fs), 32'(e.fs));
        chk("a_color", 32'(a_color), 32'(e.color));
        e = expect_vid(k, 3, 1'b0, 1'b0, bc);
        chk("b_hsync", 32'(b_hs), 32'(e.hs));
        chk("b_vsync", 32'(b_vs), 32'(e.vs));
        chk("b_de", 32'(b_de), 32'(e.de));
        chk("b_color", 32'(b_color), 32'(e.color));
        e = expect_vid(k, 4, 1'b1, 1'b1, bc);
        chk("c_hsync", 32'(c_hs), 32'(e.hs));
        chk("c_vsync", 32'(c_vs), 32'(e.vs));
        chk("c_de", 32'(c_de), 32'(e.de));
        chk("c_frame_start", 32'(c_fs), 32'(e.fs));
        chk("c_color", 32'(c_color), 32'(e.color));
    endtask

    initial begin
        reset_n = 1'b0;
        border  = 8'hFF;
        // Reset, then two full frames with a white border.
        repeat (3) step(1'b0, 8'hFF);
        repeat (2 * FRAME) step(1'b1, 8'hFF);
        // Random border colours over a further frame.
        repeat (FRAME) step(1'b1, 8'($urandom));
        // Mid-frame reset at h=10, v=5 held for two edges.
        while (k % FRAME != 5 * HT + 10) step(1'b1, 8'($urandom));
        repeat (2) step(1'b0, 8'($urandom));
        repeat (FRAME + 16) step(1'b1, 8'($urandom));
        // One-cycle reset at a random point.
        repeat ($urandom_range(10, FRAME - 1)) step(1'b1, 8'($urandom));
        step(1'b0, 8'($urandom));
        repeat (FRAME + 16) step(1'b1, 8'($urandom));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
